// File: rtl/fpga_link_pkg.sv
// Shared definitions for the FPGA-to-FPGA parallel link endpoints (rx now, tx later).
package fpga_link_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        RECV  = 2'd2,
        ACK   = 2'd3
    } link_state_e;

    localparam int CNT_W = 16;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/fpga_link_sync_fifo.sv
// Single-clock first-word-fall-through FIFO; the head word is held in a register
// so data_o is valid the cycle after the first push and clears to zero on reset.
module fpga_link_sync_fifo #(
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 512
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        push_i,
    input  logic [DATA_W-1:0]           push_data_i,
    input  logic                        pop_i,
    output logic [DATA_W-1:0]           data_o,
    output logic [$clog2(FIFO_DEPTH):0] level_o,
    output logic                        full_o,
    output logic                        empty_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_L = (AW+1)'(FIFO_DEPTH);

    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW:0]       count_q, count_d;
    logic [DATA_W-1:0] head_q, head_d;
    logic              do_push, do_pop;

    // The head register loads the word that will sit at the read pointer after
    // this cycle, bypassing the RAM when that word is being pushed right now.
    always_comb begin
        do_pop   = pop_i && (count_q != '0);
        do_push  = push_i && ((count_q != DEPTH_L) || do_pop);
        count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        head_d   = head_q;
        if (count_d != '0) begin
            if (do_push && ((count_q - (AW+1)'(do_pop)) == '0)) begin
                head_d = push_data_i;
            end else begin
                head_d = mem_q[rd_ptr_d];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
        end
    end

    assign data_o  = head_q;
    assign level_o = count_q;
    assign full_o  = (count_q == DEPTH_L);
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/fpga_link_rx.sv
// Receive endpoint of the FPGA-to-FPGA link: credit-checked burst handshake,
// toggle-strobed word capture into a FIFO, and a valid/ready stream out.
module fpga_link_rx
    import fpga_link_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int FIFO_DEPTH  = 512,
    parameter int MAX_BURST   = 64,
    parameter int SYNC_STAGES = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [DATA_W-1:0]           link_data,
    input  logic                        link_req,
    input  logic                        link_wtog,
    input  logic                        link_done,
    output logic                        link_rdy,
    output logic                        link_ack,
    output logic                        link_err,
    output logic [DATA_W-1:0]           m_data,
    output logic                        m_valid,
    input  logic                        m_ready,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic [CNT_W-1:0]            burst_cnt,
    output logic [CNT_W-1:0]            err_cnt
);

    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
    localparam int WC_W  = $clog2(MAX_BURST + 1);
    localparam logic [LVL_W-1:0] CREDIT_LVL = LVL_W'(FIFO_DEPTH - MAX_BURST);
    localparam logic [WC_W-1:0]  WCNT_MAX   = WC_W'(MAX_BURST);

    logic [SYNC_STAGES-1:0] req_sync_q, done_sync_q, wtog_sync_q;
    logic                   wtog_prev_q;
    logic                   req_s, done_s, wtog_s, word_evt;

    link_state_e       state_q, state_d;
    logic              rdy_q, rdy_d;
    logic              ack_q, ack_d;
    logic              err_q, err_d;
    logic [WC_W-1:0]   wcnt_q, wcnt_d;
    logic [CNT_W-1:0]  burst_cnt_q, burst_cnt_d;
    logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;

    logic              push, pop, drop, abort;
    logic              fifo_full, fifo_empty;
    logic [LVL_W-1:0]  fifo_lvl;

    always_ff @(posedge clk) begin
        if (rst) begin
            req_sync_q  <= '0;
            done_sync_q <= '0;
            wtog_sync_q <= '0;
            wtog_prev_q <= 1'b0;
        end else begin
            req_sync_q  <= {req_sync_q[SYNC_STAGES-2:0], link_req};
            done_sync_q <= {done_sync_q[SYNC_STAGES-2:0], link_done};
            wtog_sync_q <= {wtog_sync_q[SYNC_STAGES-2:0], link_wtog};
            wtog_prev_q <= wtog_sync_q[SYNC_STAGES-1];
        end
    end

    assign req_s    = req_sync_q[SYNC_STAGES-1];
    assign done_s   = done_sync_q[SYNC_STAGES-1];
    assign wtog_s   = wtog_sync_q[SYNC_STAGES-1];
    assign word_evt = wtog_s ^ wtog_prev_q;
    assign pop      = m_ready && !fifo_empty;

    // Words only land while a burst is granted; a word in the same cycle as
    // done is still written because capture is independent of the transition.
    always_comb begin
        state_d     = state_q;
        rdy_d       = rdy_q;
        ack_d       = ack_q;
        wcnt_d      = wcnt_q;
        burst_cnt_d = burst_cnt_q;
        push        = 1'b0;
        drop        = 1'b0;
        abort       = 1'b0;
        case (state_q)
            IDLE: begin
                rdy_d  = 1'b0;
                ack_d  = 1'b0;
                wcnt_d = '0;
                if (req_s && !done_s && (fifo_lvl <= CREDIT_LVL)) begin
                    state_d = GRANT;
                end
            end
            GRANT: begin
                rdy_d   = 1'b1;
                state_d = RECV;
            end
            RECV: begin
                if (word_evt) begin
                    if (wcnt_q == WCNT_MAX) begin
                        drop = 1'b1;
                    end else begin
                        wcnt_d = wcnt_q + WC_W'(1);
                        if (fifo_full && !pop) begin
                            drop = 1'b1;
                        end else begin
                            push = 1'b1;
                        end
                    end
                end
                if (done_s) begin
                    state_d = ACK;
                end else if (!req_s) begin
                    abort   = 1'b1;
                    rdy_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            ACK: begin
                rdy_d = 1'b0;
                ack_d = 1'b1;
                if (!ack_q) begin
                    burst_cnt_d = burst_cnt_q + CNT_W'(1);
                end else if (!req_s && !done_s) begin
                    ack_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                rdy_d   = 1'b0;
                ack_d   = 1'b0;
            end
        endcase
        err_d     = abort || drop;
        err_cnt_d = err_d ? sat_inc(err_cnt_q) : err_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rdy_q       <= 1'b0;
            ack_q       <= 1'b0;
            err_q       <= 1'b0;
            wcnt_q      <= '0;
            burst_cnt_q <= '0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            rdy_q       <= rdy_d;
            ack_q       <= ack_d;
            err_q       <= err_d;
            wcnt_q      <= wcnt_d;
            burst_cnt_q <= burst_cnt_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    fpga_link_sync_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push),
        .push_data_i (link_data),
        .pop_i       (pop),
        .data_o      (m_data),
        .level_o     (fifo_lvl),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    assign link_rdy   = rdy_q;
    assign link_ack   = ack_q;
    assign link_err   = err_q;
    assign m_valid    = !fifo_empty;
    assign fifo_level = fifo_lvl;
    assign burst_cnt  = burst_cnt_q;
    assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_fpga_link_rx.sv
// Self-checking bench for fpga_link_rx: table of burst scenarios plus directed
// sequences for credit, coincident events, FIFO full push/pop and reset mid-burst.
module tb_fpga_link_rx;

    localparam int DW    = 32;
    localparam int DEPTH = 32;
    localparam int MB    = 8;
    localparam int SS    = 2;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] link_data;
    logic          link_req, link_wtog, link_done;
    logic          link_rdy, link_ack, link_err;
    logic [DW-1:0] m_data;
    logic          m_valid, m_ready;
    logic [LW-1:0] fifo_level;
    logic [15:0]   burst_cnt, err_cnt;

    logic          fPush, fPop, fFull, fEmpty;
    logic [DW-1:0] fPushData, fData;
    logic [2:0]    fLevel;

    int checksTotal  = 0;
    int checksPassed = 0;
    int errPulses    = 0;

    typedef struct {
        int          nWords;
        logic [31:0] base;
        bit          abort;
        int          expStored;
        int          expErrs;
        bit          expAck;
    } burstVec_t;

    burstVec_t vecs[4];

    always #5 clk = ~clk;

    fpga_link_rx #(
        .DATA_W      (DW),
        .FIFO_DEPTH  (DEPTH),
        .MAX_BURST   (MB),
        .SYNC_STAGES (SS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .link_data  (link_data),
        .link_req   (link_req),
        .link_wtog  (link_wtog),
        .link_done  (link_done),
        .link_rdy   (link_rdy),
        .link_ack   (link_ack),
        .link_err   (link_err),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .fifo_level (fifo_level),
        .burst_cnt  (burst_cnt),
        .err_cnt    (err_cnt)
    );

    fpga_link_sync_fifo #(
        .DATA_W     (DW),
        .FIFO_DEPTH (4)
    ) smallFifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (fPush),
        .push_data_i (fPushData),
        .pop_i       (fPop),
        .data_o      (fData),
        .level_o     (fLevel),
        .full_o      (fFull),
        .empty_o     (fEmpty)
    );

    always @(negedge clk) begin
        if (!rst && link_err) errPulses <= errPulses + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checksTotal++;
        if (actual === expected) checksPassed++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    endtask

    task automatic waitRdy(output int cyc, output bit seen);
        seen = 1'b0;
        cyc  = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            tick();
            cyc++;
            if (link_rdy) seen = 1'b1;
        end
    endtask

    task automatic startBurst(output int cyc, output bit seen);
        link_req = 1'b1;
        waitRdy(cyc, seen);
    endtask

    task automatic sendWord(input logic [31:0] d);
        link_data = d;
        link_wtog = ~link_wtog;
        repeat (SS + 3) tick();
    endtask

    task automatic finishBurst(output int cyc, output bit seen);
        link_done = 1'b1;
        seen = 1'b0;
        cyc  = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            tick();
            cyc++;
            if (link_ack) seen = 1'b1;
        end
        link_req  = 1'b0;
        link_done = 1'b0;
        for (int i = 0; i < 40 && link_ack; i++) tick();
        checkOutput("ackRelease", link_ack, 0);
    endtask

    task automatic drainCheck(input logic [31:0] base, input int n);
        for (int k = 0; k < n; k++) begin
            checkOutput($sformatf("drainData%0d", k), m_data, base + k);
            m_ready = 1'b1;
            tick();
            m_ready = 1'b0;
        end
        checkOutput("drainEmpty", m_valid, 0);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "Rdy"}, link_rdy, 0);
        checkOutput({tag, "Ack"}, link_ack, 0);
        checkOutput({tag, "Err"}, link_err, 0);
        checkOutput({tag, "Valid"}, m_valid, 0);
        checkOutput({tag, "Data"}, m_data, 0);
        checkOutput({tag, "Level"}, fifo_level, 0);
        checkOutput({tag, "BurstCnt"}, burst_cnt, 0);
        checkOutput({tag, "ErrCnt"}, err_cnt, 0);
    endtask

    task automatic applyStimulus(input int idx, input burstVec_t v);
        int  e0, p0, b0, cyc;
        bit  seen, ackSeen;
        e0 = int'(err_cnt);
        p0 = errPulses;
        b0 = int'(burst_cnt);
        startBurst(cyc, seen);
        checkOutput($sformatf("v%0d rdyLatency", idx), seen ? cyc : -1, SS + 2);
        for (int k = 0; k < v.nWords; k++) sendWord(v.base + k);
        ackSeen = 1'b0;
        if (v.abort) begin
            link_req = 1'b0;
            repeat (12) begin
                tick();
                if (link_ack) ackSeen = 1'b1;
            end
            checkOutput($sformatf("v%0d abortRdy", idx), link_rdy, 0);
        end else begin
            finishBurst(cyc, ackSeen);
            checkOutput($sformatf("v%0d ackLatency", idx), cyc, SS + 2);
        end
        repeat (2) tick();
        checkOutput($sformatf("v%0d ackSeen", idx), ackSeen, v.expAck);
        checkOutput($sformatf("v%0d level", idx), fifo_level, v.expStored);
        checkOutput($sformatf("v%0d errCnt", idx), int'(err_cnt) - e0, v.expErrs);
        checkOutput($sformatf("v%0d errPulses", idx), errPulses - p0, v.expErrs);
        checkOutput($sformatf("v%0d burstCnt", idx), int'(burst_cnt) - b0, v.expAck);
        drainCheck(v.base, v.expStored);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int  cyc, p0;
        bit  seen;

        rst = 1'b1;
        link_data = '0; link_req = 1'b0; link_wtog = 1'b0; link_done = 1'b0;
        m_ready = 1'b0;
        fPush = 1'b0; fPop = 1'b0; fPushData = '0;

        repeat (3) tick();
        checkResetValues("reset");
        rst = 1'b0;
        repeat (2) tick();

        vecs[0] = '{nWords: 8,  base: 32'h1,   abort: 1'b0, expStored: 8, expErrs: 0, expAck: 1'b1};
        vecs[1] = '{nWords: 10, base: 32'h100, abort: 1'b0, expStored: 8, expErrs: 2, expAck: 1'b1};
        vecs[2] = '{nWords: 3,  base: 32'h200, abort: 1'b1, expStored: 3, expErrs: 1, expAck: 1'b0};
        vecs[3] = '{nWords: 5,  base: 32'h300, abort: 1'b0, expStored: 5, expErrs: 0, expAck: 1'b1};
        for (int i = 0; i < 4; i++) applyStimulus(i, vecs[i]);

        // Last word toggle and done together, with a pop landing on the write edge.
        p0 = errPulses;
        startBurst(cyc, seen);
        sendWord(32'hA1);
        sendWord(32'hA2);
        link_data = 32'hA3;
        link_wtog = ~link_wtog;
        link_done = 1'b1;
        repeat (SS) tick();
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        checkOutput("simulLevel", fifo_level, 2);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            if (link_ack) seen = 1'b1;
            else tick();
        end
        checkOutput("simulAck", seen, 1);
        link_req = 1'b0;
        link_done = 1'b0;
        for (int i = 0; i < 40 && link_ack; i++) tick();
        checkOutput("simulErrs", errPulses - p0, 0);
        drainCheck(32'hA2, 2);

        // Fill to one word beyond the credit threshold; grant must wait for a pop.
        for (int b = 0; b < 4; b++) begin
            startBurst(cyc, seen);
            checkOutput($sformatf("fillRdy%0d", b), seen, 1);
            for (int k = 0; k < ((b < 3) ? MB : 1); k++) sendWord(32'h400 + 32'(b * 16 + k));
            finishBurst(cyc, seen);
            repeat (2) tick();
        end
        checkOutput("fillLevel", fifo_level, DEPTH - MB + 1);
        link_req = 1'b1;
        seen = 1'b0;
        repeat (20) begin
            tick();
            if (link_rdy) seen = 1'b1;
        end
        checkOutput("noCreditRdy", seen, 0);
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        waitRdy(cyc, seen);
        checkOutput("creditRdy", seen && (cyc <= SS + 2), 1);
        finishBurst(cyc, seen);
        checkOutput("creditLevel", fifo_level, DEPTH - MB);
        checkOutput("creditHead", m_data, 32'h401);
        m_ready = 1'b1;
        for (int i = 0; i < 64 && m_valid; i++) tick();
        m_ready = 1'b0;
        checkOutput("creditDrain", fifo_level, 0);

        // Full FIFO: push with a pop in the same cycle keeps the level.
        for (int i = 0; i < 4; i++) begin
            fPush = 1'b1;
            fPushData = 32'hF0 + 32'(i);
            tick();
        end
        fPush = 1'b0;
        checkOutput("fifoFull", fFull, 1);
        checkOutput("fifoLevelFull", fLevel, 4);
        fPush = 1'b1; fPushData = 32'hF4; fPop = 1'b1;
        tick();
        fPush = 1'b0; fPop = 1'b0;
        checkOutput("fifoPushPopLevel", fLevel, 4);
        checkOutput("fifoPushPopHead", fData, 32'hF1);
        fPush = 1'b1; fPushData = 32'hF5;
        tick();
        fPush = 1'b0;
        checkOutput("fifoRejectLevel", fLevel, 4);
        for (int i = 1; i <= 4; i++) begin
            checkOutput($sformatf("fifoDrain%0d", i), fData, 32'hF0 + 32'(i));
            fPop = 1'b1;
            tick();
            fPop = 1'b0;
        end
        checkOutput("fifoEmpty", fEmpty, 1);

        // Reset in the middle of a burst.
        startBurst(cyc, seen);
        sendWord(32'h500);
        sendWord(32'h501);
        checkOutput("preResetRdy", link_rdy, 1);
        rst = 1'b1;
        tick();
        checkResetValues("midReset");
        rst = 1'b0;
        link_req = 1'b0;
        repeat (4) tick();

        $display("%0d/%0d checks passed", checksPassed, checksTotal);
        $finish;
    end

endmodule

// File: doc/fpga_link_rx.md
# fpga_link_rx

Parametrised receive endpoint for the FPGA-to-FPGA parallel link on the FPGA 2 side. It performs burst-level request/ready/done/acknowledge handshaking with the remote sender and captures words strobed by a per-word toggle through synchronisers. Captured words go into an internal FIFO. The FIFO drains as a valid/ready stream toward downstream processing (DRAM writer). Compared with the single-word receiver, it adds a credit-checked burst grant, a per-word strobe, burst length limits, abort detection and error counters.

## Interface
- DATA_W, 32, link and stream data width
- FIFO_DEPTH, 512, words in internal FIFO (power of two, ≥ 2×MAX_BURST)
- MAX_BURST, 64, maximum words granted per burst
- SYNC_STAGES, 2, flip-flops per input synchroniser (≥ 2)
- clk  in  1  receive clock
- rst  in  1  reset, synchronous, active-high
- link_data  in  DATA_W  word from sender; stable whenever link_wtog is unchanged
- link_req  in  1  burst request level from sender (asynchronous)
- link_wtog  in  1  word strobe; each toggle means a new word on link_data (asynchronous)
- link_done  in  1  burst complete level from sender (asynchronous)
- link_rdy  out  1  burst granted
- link_ack  out  1  burst accepted
- link_err  out  1  one-cycle pulse on abort or overrun
- m_data  out  DATA_W  head of FIFO (first-word fall-through)
- m_valid  out  1  FIFO not empty
- m_ready  in  1  downstream pop
- fifo_level  out  $clog2(FIFO_DEPTH)+1  words stored
- burst_cnt  out  16  completed bursts, wraps
- err_cnt  out  16  aborts plus dropped words, saturates at 0xFFFF

## Operation
- req_s, done_s, wtog_s: outputs of the synchronisers. word_evt = wtog_s XOR previous wtog_s. On word_evt, link_data is captured directly; the sender holds data ≥ SYNC_STAGES+2 clk periods per word.
- States:
  - **IDLE**: rdy=0, ack=0, word count cleared. When req_s=1, done_s=0 and free = FIFO_DEPTH − fifo_level ≥ MAX_BURST, go to GRANT. Otherwise stay.
  - **GRANT**: rdy←1, go to RECV.
  - **RECV**:
    - Each word_evt writes link_data and increments wcnt.
    - On word_evt with wcnt = MAX_BURST: drop the word, pulse err, increment err_cnt, stay in RECV.
    - On done_s=1: go to ACK. A word_evt in the same cycle is written first.
    - On req_s=0 with done_s=0 (abort): pulse err, increment err_cnt, rdy←0, go to IDLE. Words already written stay in the FIFO.
  - **ACK**: rdy←0, ack←1, burst_cnt+1 (once, on entry). Hold ack until req_s=0 and done_s=0, then ack←0 and go to IDLE.
- The FIFO write is suppressed only when the FIFO is full and no pop occurs that cycle. A suppressed write counts as a drop (err pulse, err_cnt+1). The credit check makes this unreachable in normal use.
- A pop occurs when m_valid & m_ready. A pop when empty has no effect.
- Unreachable state encodings go to IDLE with rdy=0, ack=0.

## Timing
- Reset values: link_rdy=0, link_ack=0, link_err=0, m_valid=0, m_data=0, fifo_level=0, burst_cnt=0, err_cnt=0. Synchroniser flops clear to 0. FIFO pointers clear. The state returns to IDLE from any state, including mid-burst.
- link_req edge → link_rdy high: SYNC_STAGES+2 cycles when credit is available.
- wtog edge → FIFO write: SYNC_STAGES+1 cycles. Write → m_valid: 1 cycle.
- done edge → link_ack high: SYNC_STAGES+2 cycles.
- All outputs are registered. link_err is exactly one cycle wide per event. Two events in one cycle give one pulse and err_cnt+1.
- fifo_level updates the cycle after the push/pop. A simultaneous push and pop leaves it unchanged.

## Structure
- Package fpga_link_pkg:
  - state enum {IDLE, GRANT, RECV, ACK}
  - counter width constant CNT_W=16
  - shared by the future fpga_link_tx
- Sub-module fpga_link_sync_fifo: single-clock FWFT FIFO with parameters DATA_W and FIFO_DEPTH, ports push/pop/level/full/empty. This replaces the vendor FIFO IP.
- Synchronisers are inline shift registers, parametrised by SYNC_STAGES.

## Test plan
- **Normal burst**: 8-word burst 0x1..0x8 → rdy, 8 writes, ack, burst_cnt=1, m_data pops 0x1..0x8 in order, err_cnt=0.
- **No credit**: fill the FIFO to FIFO_DEPTH−MAX_BURST+1 with m_ready=0, then req → rdy stays 0. Pop 1 word → rdy rises SYNC_STAGES+2 or fewer cycles later.
- **Overrun**: MAX_BURST+2 toggles → MAX_BURST words stored, 2 err pulses, err_cnt=2, ack still given.
- **Abort**: req drops after 3 words with no done → err pulse, err_cnt=1, no ack, fifo_level=3, returns to IDLE and the next burst is accepted.
- **Reset mid-burst**: rst asserted in RECV → all outputs at reset values the next cycle, fifo_level=0.
- **Simultaneous events**: last word toggle and done edge in the same cycle → word stored, then ack. Full FIFO with a pop in the same cycle as a push → no drop, level unchanged.
